// File: rtl/time_compare_sequencer.sv
// time_compare_sequencer: scans two packed BCD values MSD-first through an external digit comparator; EARLY_EXIT_EN stops at the first deciding digit
module time_compare_sequencer #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   time_a,
  input  logic [4*DIGITS-1:0]   time_b,
  output logic                  busy,
  output logic                  done,
  output logic                  gt,
  output logic                  eq,
  output logic                  lt,
  output logic                  err,
  output logic [3:0]            cmp_a,
  output logic [3:0]            cmp_b,
  output logic                  cmp_en,
  input  logic                  cmp_l,
  input  logic                  cmp_e,
  input  logic                  cmp_r
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d;
  logic                gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d, dec_q, dec_d;
  logic                perr, last, early;
`ifdef EARLY_EXIT_EN
  assign early = 1'b1;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;
    dec_d   = dec_q;
    last    = 1'b0;
    cmp_en  = state_q == SCAN;
    busy    = cmp_en;
    done    = state_q == DONE;
    cmp_a   = cmp_en ? a_q[4*idx_q +: 4] : 4'd0;
    cmp_b   = cmp_en ? b_q[4*idx_q +: 4] : 4'd0;
    perr    = cmp_en & ~$onehot({cmp_l, cmp_e, cmp_r});
    if (state_q == SCAN) begin
      if (perr) begin
        err_d = 1'b1;
        dec_d = 1'b1;
      end else if (!dec_q && cmp_l) begin
        gt_d  = 1'b1;
        dec_d = 1'b1;
      end else if (!dec_q && cmp_r) begin
        lt_d  = 1'b1;
        dec_d = 1'b1;
      end
      last  = idx_q == '0 || (early && dec_d);
      idx_d = idx_q - 1'b1;
      if (last) begin
        // an error anywhere in the scan voids the magnitude result
        state_d = DONE;
        gt_d    = gt_d & ~err_d;
        lt_d    = lt_d & ~err_d;
        eq_d    = ~dec_d & ~err_d;
      end
    end else if (start) begin
      state_d = SCAN;
      a_d     = time_a;
      b_d     = time_b;
      idx_d   = IW'(DIGITS - 1);
      gt_d    = 1'b0;
      eq_d    = 1'b0;
      lt_d    = 1'b0;
      err_d   = 1'b0;
      dec_d   = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end
  assign gt  = gt_q;
  assign eq  = eq_q;
  assign lt  = lt_q;
  assign err = err_q;
endmodule

// File: tb/tb_time_compare_sequencer.sv
// tb_time_compare_sequencer: table, directed and random checks with a looped-back digit comparator (or faulty stub)
module tb_time_compare_sequencer;
  localparam int D = 6;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stub = 1'b0;
  logic [4*D-1:0] ta = '0, tbv = '0;
  logic          busy, done, gt, eq, lt, err, cmp_en, cmp_l, cmp_e, cmp_r;
  logic [3:0]    cmp_a, cmp_b;
  int            en_n = 0, nerr = 0, nchk = 0;
  typedef struct {logic [4*D-1:0] a, b; logic g, e, l; int lat;} vec_t;
  vec_t tv[5];
  time_compare_sequencer #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .time_a(ta), .time_b(tbv),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_en(cmp_en),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_r(cmp_r)
  );
  always #5 clk = ~clk;
  always_comb begin
    if (stub && cmp_en && en_n == 2) begin
      cmp_l = 1'b1;
      cmp_e = 1'b1;
      cmp_r = 1'b1;
    end else begin
      cmp_l = cmp_a > cmp_b;
      cmp_e = cmp_a == cmp_b;
      cmp_r = cmp_a < cmp_b;
    end
  end
  always @(posedge clk) begin
    if (start && !busy) en_n <= 0;
    else if (cmp_en) en_n <= en_n + 1;
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic start_cmp(input logic [4*D-1:0] a, input logic [4*D-1:0] b);
    ta = a;
    tbv = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int l0, output int lat, output int en_cnt);
    lat = l0;
    en_cnt = 0;
    while (!done && lat < 40) begin
      en_cnt += int'(cmp_en);
      @(posedge clk);
      #1 lat++;
    end
    if (!done) begin
      nchk++;
      nerr++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
  endtask
  function automatic void model(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                                output logic g, output logic e, output logic l, output int lat);
    logic [4*D-1:0] x;
    g = a > b;
    e = a == b;
    l = a < b;
    x = a ^ b;
    lat = D + 1;
    if (EE && x != 0) for (int i = 0; i < D; i++) if (x[4*i +: 4] != 0) lat = D - i + 1;
  endfunction
  task automatic run_check(input string n, input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                           input logic g, input logic e, input logic l, input int elat);
    int lat, ec;
    start_cmp(a, b);
    wait_done(1, lat, ec);
    chk({n, " latency"}, lat, elat);
    chk({n, " result"}, {busy, gt, eq, lt, err}, {1'b0, g, e, l, 1'b0});
    chk({n, " scan cycles"}, ec, elat - 1);
    @(posedge clk);
    #1 chk({n, " held"}, {done, gt, eq, lt}, {1'b0, g, e, l});
  endtask
  initial begin
    int lat, ec, dseen;
    logic g, e, l;
    logic [4*D-1:0] a, b;
    tv[0] = '{24'h123456, 24'h123456, 1'b0, 1'b1, 1'b0, 7};
    tv[1] = '{24'h123500, 24'h123459, 1'b1, 1'b0, 1'b0, EE ? 5 : 7};
    tv[2] = '{24'h095959, 24'h100000, 1'b0, 1'b0, 1'b1, EE ? 2 : 7};
    tv[3] = '{24'h000000, 24'h000009, 1'b0, 1'b0, 1'b1, 7};
    tv[4] = '{24'hF00000, 24'h9FFFFF, 1'b1, 1'b0, 1'b0, EE ? 2 : 7};
    repeat (2) @(posedge clk);
    #1 chk("reset outputs", {busy, done, gt, eq, lt, err, cmp_en, cmp_a, cmp_b}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) run_check($sformatf("T%0d", i + 1), tv[i].a, tv[i].b, tv[i].g, tv[i].e, tv[i].l, tv[i].lat);
    stub = 1'b1;
    start_cmp(24'h111111, 24'h111111);
    wait_done(1, lat, ec);
    chk("T4 latency", lat, EE ? 4 : 7);
    chk("T4 err result", {gt, eq, lt, err}, 4'b0001);
    stub = 1'b0;
    @(posedge clk);
    #1 run_check("T4 clean", 24'h111111, 24'h111111, 1'b0, 1'b1, 1'b0, 7);
    start_cmp(24'h000001, 24'h000002);
    ta = 24'h999999;
    tbv = 24'h000000;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    chk("T5 busy", busy, 1'b1);
    wait_done(3, lat, ec);
    chk("T5 latency", lat, 7);
    chk("T5 first result", {gt, eq, lt, err}, 4'b0010);
    ta = 24'h200000;
    tbv = 24'h100000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("T5 back-to-back accept", {busy, done, gt, eq, lt}, 5'b10000);
    wait_done(1, lat, ec);
    chk("T5 b2b latency", lat, EE ? 2 : 7);
    chk("T5 b2b result", {gt, eq, lt, err}, 4'b1000);
    @(posedge clk);
    #1 start_cmp(24'h123456, 24'h123457);
    repeat (3) @(posedge clk);
    #1 chk("T6 digit2", {busy, cmp_a, cmp_b}, {1'b1, 4'h4, 4'h4});
    rst = 1'b1;
    @(posedge clk);
    #1 chk("T6 reset outputs", {busy, done, gt, eq, lt, err, cmp_en, cmp_a, cmp_b}, 0);
    rst = 1'b0;
    dseen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 dseen += int'(done);
    end
    chk("T6 no done", dseen, 0);
    run_check("T6 after", 24'h123456, 24'h123457, 1'b0, 1'b0, 1'b1, 7);
    for (int i = 0; i < 40; i++) begin
      a = 24'($urandom);
      b = a;
      for (int k = 0; k < D; k++) if ($urandom_range(0, 5) == 0) b[4*k +: 4] = 4'($urandom);
      model(a, b, g, e, l, lat);
      run_check($sformatf("rand%0d", i), a, b, g, e, l, lat);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
